// File: rtl/sprite_pkg.sv
// Sprite register map: register offsets, field positions and helpers.
package sprite_pkg;

    localparam int          COORD_W     = 12;
    localparam logic [1:0]  REG_POS     = 2'd0;
    localparam logic [1:0]  REG_CTRL    = 2'd1;
    localparam int          POS_H_LSB   = 0;
    localparam int          POS_V_LSB   = 16;
    localparam int          CTRL_EN_BIT = 0;

    typedef enum logic {S_IDLE, S_ACK} resp_state_t;

    // Build the POS register image; unused bits read as 0.
    function automatic logic [31:0] pos_word(input logic [COORD_W-1:0] h,
                                             input logic [COORD_W-1:0] v);
        logic [31:0] w;
        w = '0;
        w[POS_H_LSB +: COORD_W] = h;
        w[POS_V_LSB +: COORD_W] = v;
        return w;
    endfunction

    // Byte-lane merge: lane k takes the new data only when sel[k] is set.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return w;
    endfunction

endpackage

// File: rtl/wishbone_pkg.sv
// Wishbone B4 classic bus types for a 32-bit data path.
package wishbone_pkg;

    // Initiator-to-responder request
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_write_request32_t;

    // Responder-to-initiator response
    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] dat;
    } wb_read_response32_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector; reset value of the history flop is selectable so
// a level already high at reset release is not mistaken for an edge.
module edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= RST_VAL;
        else        r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/sprite_reg_responder.sv
// Wishbone responder for double-buffered sprite position/enable registers.
// Bus writes land in staging; a vsync rising edge copies staging to active,
// which the video side reads through a registered port.
module sprite_reg_responder
    import wishbone_pkg::*;
    import sprite_pkg::*;
#(
    parameter int NSPR = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  wb_write_request32_t wb_req,
    output wb_read_response32_t wb_resp,
    input  logic                vsync,
    input  logic [4:0]          spr_sel,
    output logic [11:0]         spr_hpos,
    output logic [11:0]         spr_vpos,
    output logic                spr_en
);

    resp_state_t                     r_state, w_next;
    logic [NSPR-1:0][COORD_W-1:0]    r_stg_h, r_stg_v, r_act_h, r_act_v;
    logic [NSPR-1:0]                 r_stg_en, r_act_en;
    logic [31:0]                     r_rdat;
    logic                            w_ack, w_accept, w_vs_rise, w_hit;
    logic [4:0]                      w_spr;
    logic [1:0]                      w_reg;
    logic [31:0]                     w_pos_old, w_ctrl_old, w_rd_word, w_wr_word;
    logic [COORD_W-1:0]              w_vh, w_vv;
    logic                            w_ven;
    logic                            w_unused;

    assign w_unused = &{1'b0, wb_req.adr[31:9], wb_req.adr[1:0]};

    edge_det #(.RST_VAL(1'b1)) u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (vsync),
        .o_rise (w_vs_rise)
    );

    assign w_ack    = (r_state == S_ACK);
    assign w_accept = (r_state == S_IDLE) & cs & wb_req.cyc & wb_req.stb & ~w_ack;

    // Bus address decode, staging read mux and byte-merged write word
    always_comb begin
        w_spr      = wb_req.adr[8:4];
        w_reg      = wb_req.adr[3:2];
        w_hit      = 1'b0;
        w_pos_old  = '0;
        w_ctrl_old = '0;
        for (int i = 0; i < NSPR; i++) begin
            if (w_spr == 5'(i)) begin
                w_hit      = 1'b1;
                w_pos_old  = pos_word(r_stg_h[i], r_stg_v[i]);
                w_ctrl_old = 32'(r_stg_en[i]) << CTRL_EN_BIT;
            end
        end
        w_rd_word = '0;
        if (w_hit) begin
            case (w_reg)
                REG_POS:  w_rd_word = w_pos_old;
                REG_CTRL: w_rd_word = w_ctrl_old;
                default:  w_rd_word = '0;
            endcase
        end
        w_wr_word = sel_merge((w_reg == REG_POS) ? w_pos_old : w_ctrl_old,
                              wb_req.dat, wb_req.sel);
    end

    // Handshake next-state: hold ACK until the initiator drops stb or cyc
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ACK;
            S_ACK:   if (!wb_req.stb || !wb_req.cyc) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Read data captured at accept, held through ACK, cleared on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_rdat <= '0;
        else if (w_accept)                    r_rdat <= wb_req.we ? '0 : w_rd_word;
        else if (w_ack && w_next == S_IDLE)   r_rdat <= '0;
    end

    // Staging registers take bus writes in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_h  <= '0;
            r_stg_v  <= '0;
            r_stg_en <= '0;
        end else if (w_accept && wb_req.we && w_hit) begin
            for (int i = 0; i < NSPR; i++) begin
                if (w_spr == 5'(i)) begin
                    if (w_reg == REG_POS) begin
                        r_stg_h[i] <= w_wr_word[POS_H_LSB +: COORD_W];
                        r_stg_v[i] <= w_wr_word[POS_V_LSB +: COORD_W];
                    end else if (w_reg == REG_CTRL) begin
                        r_stg_en[i] <= w_wr_word[CTRL_EN_BIT];
                    end
                end
            end
        end
    end

    // Active registers snapshot staging on vsync rise; a same-cycle write
    // is not yet visible in staging, so it waits for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_h  <= '0;
            r_act_v  <= '0;
            r_act_en <= '0;
        end else if (w_vs_rise) begin
            r_act_h  <= r_stg_h;
            r_act_v  <= r_stg_v;
            r_act_en <= r_stg_en;
        end
    end

    // Video-side lookup; out-of-range index yields 0
    always_comb begin
        w_vh  = '0;
        w_vv  = '0;
        w_ven = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            if (spr_sel == 5'(i)) begin
                w_vh  = r_act_h[i];
                w_vv  = r_act_v[i];
                w_ven = r_act_en[i];
            end
        end
    end

    // Registered video-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_hpos <= '0;
            spr_vpos <= '0;
            spr_en   <= 1'b0;
        end else begin
            spr_hpos <= w_vh;
            spr_vpos <= w_vv;
            spr_en   <= w_ven;
        end
    end

    // Response bus: only ack and dat are meaningful
    always_comb begin
        wb_resp     = '0;
        wb_resp.ack = w_ack;
        wb_resp.dat = r_rdat;
    end

endmodule

// File: doc/sprite_reg_responder.md
SPRITE_REG_RESPONDER -- requirements
Module: sprite_reg_responder

Interface
REQ-001 SHALL have parameter NSPR, default 32, meaning number of sprites (1..32).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cs  input  1  responder chip select.
REQ-005 SHALL have port wb_req  input  wb_write_request32_t  Wishbone request (cyc, stb, we, sel[3:0], adr, dat[31:0]).
REQ-006 SHALL have port wb_resp  output  wb_read_response32_t  Wishbone response (ack, dat[31:0]); other fields driven 0.
REQ-007 SHALL have port vsync  input  1  frame sync from the video timing generator, synchronous to clk.
REQ-008 SHALL have port spr_sel  input  5  sprite index for the video-side read port.
REQ-009 SHALL have port spr_hpos  output  12  active horizontal position of sprite spr_sel, registered.
REQ-010 SHALL have port spr_vpos  output  12  active vertical position of sprite spr_sel, registered.
REQ-011 SHALL have port spr_en  output  1  active enable of sprite spr_sel, registered.

Function
REQ-012 Address decode SHALL be: sprite = adr[8:4], register = adr[3:2]; adr[1:0] and bits above 8 ignored.
REQ-013 Register 0 (POS) SHALL hold hpos in dat[11:0] and vpos in dat[27:16]; other bits read 0.
REQ-014 Register 1 (CTRL) SHALL hold enable in dat[0]; other bits read 0.
REQ-015 Registers 2 and 3 SHALL read 0 and ignore writes.
REQ-016 Sprite indices >= NSPR SHALL be acknowledged, read 0 and ignore writes.
REQ-017 A request SHALL be accepted when cs & cyc & stb & ~ack in state IDLE.
REQ-018 FSM states SHALL be IDLE, ACK: IDLE->ACK on accept; ACK->IDLE when stb or cyc is low.
REQ-019 wb_resp.ack SHALL be 1 exactly while in ACK (one cycle after accept, held until the initiator drops stb, cleared the following cycle).
REQ-020 A write SHALL update the staging registers in the accept cycle, byte lane k written only when sel[k]=1.
REQ-021 A read SHALL place the staging value on wb_resp.dat with ack and hold it stable throughout ACK; wb_resp.dat SHALL be 0 in IDLE.
REQ-022 On each vsync rising edge (vsync=1, previous sample 0) all staging registers SHALL be copied to the active registers in one cycle.
REQ-023 If a write is accepted in the same cycle as a vsync rising edge, active SHALL receive the pre-write staging value; the write SHALL reach active at the next edge.
REQ-024 spr_hpos/spr_vpos/spr_en SHALL reflect active[spr_sel] with one cycle latency; spr_sel >= NSPR SHALL yield 0.
REQ-025 A second request while in ACK SHALL not be accepted until IDLE is re-entered.

Reset
REQ-026 While rst_n=0: state=IDLE, wb_resp.ack=0, wb_resp.dat=0, all staging and active registers 0, vsync edge detector sampled as 1 (no spurious edge after reset), spr_* outputs 0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with ack=0 and no partial write retained.

Structure
REQ-028 Register offsets (POS=0, CTRL=1) and field positions SHALL be constants in a shared sprite_pkg; Wishbone types SHALL come from wishbone_pkg.
REQ-029 The vsync rising-edge detector SHALL be a sub-module named edge_det; no other sub-module.

Verification
REQ-030 Write POS sprite 5 (adr 0x050, dat 0x00C8_0190, sel 1111) -> ack one cycle after stb, held until stb low; readback returns 0x00C8_0190.
REQ-031 Same write, spr_sel=5 -> spr_hpos stays 0 until vsync rises, then 0x190 and spr_vpos 0x0C8 one cycle later.
REQ-032 Write sel=0011 dat 0xFFFF_FFFF to POS sprite 2 after reset -> readback 0x0000_0FFF.
REQ-033 Write accepted in the vsync rising-edge cycle -> active unchanged that frame, updated at the next edge.
REQ-034 Write adr 0x1F0 with NSPR=16, and reg 3 write -> ack given, readback 0, no register changes.
REQ-035 rst_n low during ACK -> ack drops immediately; after release all reads 0 and no spurious vsync copy occurs.
